// File: rtl/centroid_update_ctrl.sv
// Time-multiplexed end-of-pass centroid merge for the K-means engine.
// One shared adder folds per-engine accumulators, one external divider normalises.
module centroid_update_ctrl #(
    parameter int K = 16,
    parameter int E = 2,
    parameter int ACC_W = 24,
    parameter int CNT_W = 12,
    parameter int COL_W = 8,
    localparam int EW = (E > 1) ? $clog2(E) : 1,
    localparam int KW = (K > 1) ? $clog2(K) : 1,
    localparam int SW = ACC_W + EW,
    localparam int NW = CNT_W + EW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [K-1:0]     empty_mask,
    output logic             rd_en,
    output logic [EW-1:0]    rd_eng,
    output logic [KW-1:0]    rd_clu,
    input  logic [ACC_W-1:0] rd_r,
    input  logic [ACC_W-1:0] rd_g,
    input  logic [ACC_W-1:0] rd_b,
    input  logic [CNT_W-1:0] rd_cnt,
    output logic             div_req,
    input  logic             div_ack,
    output logic [SW-1:0]    div_num,
    output logic [NW-1:0]    div_den,
    input  logic             div_done,
    input  logic [SW-1:0]    div_quot,
    output logic             cw_en,
    output logic [KW-1:0]    cw_addr,
    output logic [COL_W-1:0] cw_r,
    output logic [COL_W-1:0] cw_g,
    output logic [COL_W-1:0] cw_b
);

    typedef enum logic [3:0] {
        IDLE, READ, DRAIN, DIV_R, DIV_G, DIV_B, WRITE, NEXT, DONE
    } state_t;

    localparam logic [SW-1:0] MAXC = SW'((1 << COL_W) - 1);

    state_t        state;
    logic [SW-1:0] r_sum, g_sum, b_sum;
    logic [NW-1:0] c_sum;
    logic [SW-1:0] r_nxt, g_nxt, b_nxt;
    logic [NW-1:0] c_nxt;
    logic [KW-1:0] k;
    logic          add_pend;
    logic          pend;
    logic          qdone;

    function automatic logic [COL_W-1:0] sat(input logic [SW-1:0] q);
        if (q > MAXC) return '1;
        return q[COL_W-1:0];
    endfunction

    // Read data lands one cycle after rd_en; add_pend marks that cycle.
    always_comb begin
        r_nxt = r_sum;
        g_nxt = g_sum;
        b_nxt = b_sum;
        c_nxt = c_sum;
        if (add_pend) begin
            r_nxt = r_sum + SW'(rd_r);
            g_nxt = g_sum + SW'(rd_g);
            b_nxt = b_sum + SW'(rd_b);
            c_nxt = c_sum + NW'(rd_cnt);
        end
    end

    assign qdone = div_done && ((div_req && div_ack) || pend);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            empty_mask <= '0;
            rd_en      <= 1'b0;
            rd_eng     <= '0;
            rd_clu     <= '0;
            div_req    <= 1'b0;
            div_num    <= '0;
            div_den    <= '0;
            cw_en      <= 1'b0;
            cw_addr    <= '0;
            cw_r       <= '0;
            cw_g       <= '0;
            cw_b       <= '0;
            r_sum      <= '0;
            g_sum      <= '0;
            b_sum      <= '0;
            c_sum      <= '0;
            k          <= '0;
            add_pend   <= 1'b0;
            pend       <= 1'b0;
        end else begin
            done     <= 1'b0;
            cw_en    <= 1'b0;
            add_pend <= rd_en;
            r_sum    <= r_nxt;
            g_sum    <= g_nxt;
            b_sum    <= b_nxt;
            c_sum    <= c_nxt;
            unique case (state)
                IDLE: if (start) begin
                    busy       <= 1'b1;
                    empty_mask <= '0;
                    k          <= '0;
                    r_sum      <= '0;
                    g_sum      <= '0;
                    b_sum      <= '0;
                    c_sum      <= '0;
                    rd_en      <= 1'b1;
                    rd_eng     <= '0;
                    rd_clu     <= '0;
                    state      <= READ;
                end
                READ: begin
                    if (rd_eng == EW'(E - 1)) begin
                        rd_en <= 1'b0;
                        state <= DRAIN;
                    end else begin
                        rd_eng <= rd_eng + 1'b1;
                    end
                end
                DRAIN: begin
                    if (c_nxt == '0) begin
                        empty_mask[k] <= 1'b1;
                        state         <= NEXT;
                    end else begin
                        div_req <= 1'b1;
                        div_num <= r_nxt;
                        div_den <= c_nxt;
                        state   <= DIV_R;
                    end
                end
                DIV_R, DIV_G, DIV_B: begin
                    if (div_req && div_ack) begin
                        div_req <= 1'b0;
                        pend    <= !div_done;
                    end
                    if (qdone) begin
                        pend <= 1'b0;
                        if (state == DIV_R) begin
                            cw_r    <= sat(div_quot);
                            div_req <= 1'b1;
                            div_num <= g_sum;
                            state   <= DIV_G;
                        end else if (state == DIV_G) begin
                            cw_g    <= sat(div_quot);
                            div_req <= 1'b1;
                            div_num <= b_sum;
                            state   <= DIV_B;
                        end else begin
                            cw_b    <= sat(div_quot);
                            cw_en   <= 1'b1;
                            cw_addr <= k;
                            state   <= WRITE;
                        end
                    end
                end
                WRITE: state <= NEXT;
                NEXT: begin
                    if (k == KW'(K - 1)) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        k      <= k + 1'b1;
                        r_sum  <= '0;
                        g_sum  <= '0;
                        b_sum  <= '0;
                        c_sum  <= '0;
                        rd_en  <= 1'b1;
                        rd_eng <= '0;
                        rd_clu <= k + 1'b1;
                        state  <= READ;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_centroid_update_ctrl.sv
// Scoreboard bench for centroid_update_ctrl: accumulator bank and divider models,
// expected writes queued at stimulus time and checked by a separate monitor.
module tb_centroid_update_ctrl;

    localparam int K = 16;
    localparam int E = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done;
    logic [15:0] empty_mask;
    logic        rd_en;
    logic [0:0]  rd_eng;
    logic [3:0]  rd_clu;
    logic [23:0] rd_r, rd_g, rd_b;
    logic [11:0] rd_cnt;
    logic        div_req, div_ack, div_done;
    logic [24:0] div_num, div_quot;
    logic [12:0] div_den;
    logic        cw_en;
    logic [3:0]  cw_addr;
    logic [7:0]  cw_r, cw_g, cw_b;

    centroid_update_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .empty_mask(empty_mask), .rd_en(rd_en), .rd_eng(rd_eng),
        .rd_clu(rd_clu), .rd_r(rd_r), .rd_g(rd_g), .rd_b(rd_b),
        .rd_cnt(rd_cnt), .div_req(div_req), .div_ack(div_ack),
        .div_num(div_num), .div_den(div_den), .div_done(div_done),
        .div_quot(div_quot), .cw_en(cw_en), .cw_addr(cw_addr),
        .cw_r(cw_r), .cw_g(cw_g), .cw_b(cw_b)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] a;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } wr_t;

    wr_t exp_q[$];
    int  n_chk = 0;
    int  n_pass = 0;
    int  wr_cnt = 0;
    int  done_cnt = 0;
    int  req_starts = 0;
    logic req_d = 1'b0;

    logic [23:0] mr[E][K], mg[E][K], mb[E][K];
    logic [11:0] mc[E][K];

    always @(posedge clk) begin
        if (rd_en) begin
            rd_r   <= mr[rd_eng][rd_clu];
            rd_g   <= mg[rd_eng][rd_clu];
            rd_b   <= mb[rd_eng][rd_clu];
            rd_cnt <= mc[rd_eng][rd_clu];
        end
    end

    // Divider model: zero-latency combinational mode, or delayed ack/done.
    bit          zl = 1'b0;
    bit          spur_en = 1'b0;
    int          ack_dly = 5;
    int          done_dly = 7;
    logic        ack_r, done_r;
    logic [24:0] quot_r, num_l;
    logic [12:0] den_l;
    int          dv, cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_r <= 1'b0; done_r <= 1'b0; quot_r <= '0;
            num_l <= '0; den_l <= '0; dv <= 0; cnt <= 0;
        end else begin
            ack_r  <= 1'b0;
            done_r <= 1'b0;
            case (dv)
                0: begin
                    if (div_req && !zl) begin
                        dv <= 1; cnt <= 1;
                        num_l <= div_num; den_l <= div_den;
                    end else if (spur_en && rd_en) begin
                        done_r <= 1'b1; quot_r <= '0;
                    end
                end
                1: begin
                    if (cnt == ack_dly - 1) begin
                        ack_r <= 1'b1; dv <= 2; cnt <= 0;
                    end else cnt <= cnt + 1;
                end
                default: begin
                    if (cnt == done_dly - 1) begin
                        done_r <= 1'b1; quot_r <= num_l / 25'(den_l); dv <= 0;
                    end else cnt <= cnt + 1;
                end
            endcase
        end
    end

    always_comb begin
        div_ack  = zl ? div_req : ack_r;
        div_done = zl ? div_req : done_r;
        div_quot = quot_r;
        if (zl) div_quot = (div_den != 0) ? div_num / 25'(div_den) : '0;
    end

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, req);
    endtask

    // Monitor: pops the scoreboard on every centroid write.
    always @(negedge clk) begin
        if (rst_n) begin
            if (cw_en) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_write: got addr %0d want none",
                             cw_addr);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("write", {rd_en, div_req, cw_addr, cw_r, cw_g, cw_b},
                        {2'b00, e});
                end
            end
            if (done) done_cnt++;
            if (!zl && dv == 1)
                chk("div_hold", {div_req, div_num, div_den},
                    {1'b1, num_l, den_l});
            if (div_req && !req_d) req_starts++;
            req_d = div_req;
        end
    end

    // mode 0: generic, 1: generic with clusters 0/3/5 special, 2: unit counts
    task automatic load_pass(input int mode, input int npush);
        for (int k = 0; k < K; k++) begin
            wr_t w;
            if (mode == 2) begin
                mr[0][k] = 24'(10 * k); mr[1][k] = 24'(10 * k);
                mg[0][k] = 24'd100;     mg[1][k] = 24'd0;
                mb[0][k] = 24'd300;     mb[1][k] = 24'd300;
                mc[0][k] = 12'd1;       mc[1][k] = 12'd1;
                w = '{a: 4'(k), r: 8'(10 * k), g: 8'd50, b: 8'd255};
            end else begin
                mr[0][k] = 24'(40 * k); mr[1][k] = 24'(40 * k);
                mg[0][k] = 24'(20 * k); mg[1][k] = 24'(20 * k);
                mb[0][k] = 24'd500;     mb[1][k] = 24'(4 * k);
                mc[0][k] = 12'd4;       mc[1][k] = 12'd4;
                w = '{a: 4'(k), r: 8'(10 * k), g: 8'(5 * k),
                      b: 8'((500 + 4 * k) / 8)};
            end
            if (mode == 1 && k == 3) begin
                mr[0][k] = 24'd1000; mg[0][k] = 24'd2000; mb[0][k] = 24'd3000;
                mr[1][k] = 24'd1000; mg[1][k] = 24'd0;    mb[1][k] = 24'd600;
                mc[0][k] = 12'd10;   mc[1][k] = 12'd10;
                w = '{a: 4'd3, r: 8'd100, g: 8'd100, b: 8'd180};
            end
            if (mode == 1 && k == 0) begin
                mr[0][k] = 24'd300; mg[0][k] = 24'd100; mb[0][k] = 24'd0;
                mr[1][k] = 24'd300; mg[1][k] = 24'd100; mb[1][k] = 24'd0;
                mc[0][k] = 12'd1;   mc[1][k] = 12'd1;
                w = '{a: 4'd0, r: 8'd255, g: 8'd100, b: 8'd0};
            end
            if (mode == 1 && k == 5) begin
                mc[0][k] = 12'd0; mc[1][k] = 12'd0;
            end
            if (k < npush && !(mode == 1 && k == 5)) exp_q.push_back(w);
        end
    endtask

    task automatic run_pass(input int extra_at, output int cyc);
        int n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!done && n < 5000) begin
            start = (n == extra_at);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk("pass_done", done, 1);
        cyc = n;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, d0, w0, r0, t;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_state", {busy, done, rd_en, div_req, cw_en, empty_mask,
            rd_eng, rd_clu, cw_addr, cw_r, cw_g, cw_b, div_num, div_den}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Slow divider, specials, empty cluster 5, stray div_done pulses
        spur_en = 1'b1;
        d0 = done_cnt; w0 = wr_cnt; r0 = req_starts;
        load_pass(1, K);
        run_pass(0, cyc);
        @(negedge clk);
        chk("a_done_once", done_cnt - d0, 1);
        chk("a_writes", wr_cnt - w0, 15);
        chk("a_queue_empty", exp_q.size(), 0);
        chk("a_empty_mask", empty_mask, 16'h0020);
        chk("a_div_requests", req_starts - r0, 45);
        chk("a_busy_low", busy, 0);

        // start pulsed while busy must be ignored
        spur_en = 1'b0;
        ack_dly = 2; done_dly = 2;
        d0 = done_cnt; w0 = wr_cnt;
        load_pass(0, K);
        run_pass(20, cyc);
        repeat (3) @(negedge clk);
        chk("b_done_once", done_cnt - d0, 1);
        chk("b_writes", wr_cnt - w0, K);
        chk("b_queue_empty", exp_q.size(), 0);
        chk("b_empty_mask", empty_mask, 0);

        // reset during DIV_G of cluster 7
        d0 = done_cnt; w0 = wr_cnt;
        load_pass(0, 7);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (wr_cnt - w0 < 7 && t < 3000) begin @(negedge clk); t++; end
        chk("c_reach_clu7", wr_cnt - w0, 7);
        r0 = req_starts;
        t = 0;
        while (req_starts - r0 < 2 && t < 3000) begin @(negedge clk); t++; end
        chk("c_reach_div_g", req_starts - r0, 2);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("c_reset_outputs", {busy, done, rd_en, div_req, cw_en,
            empty_mask, cw_addr, cw_r, cw_g, cw_b, div_num, div_den}, 0);
        repeat (3) @(negedge clk);
        chk("c_no_done", done_cnt - d0, 0);
        chk("c_queue_empty", exp_q.size(), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Zero-latency divider, unit counts, exact pass length
        zl = 1'b1;
        d0 = done_cnt; w0 = wr_cnt;
        load_pass(2, K);
        run_pass(0, cyc);
        chk("d_cycles", cyc, K * (E + 1 + 3 + 1 + 1) + 1);
        repeat (2) @(negedge clk);
        chk("d_done_once", done_cnt - d0, 1);
        chk("d_writes", wr_cnt - w0, K);
        chk("d_queue_empty", exp_q.size(), 0);
        chk("d_empty_mask", empty_mask, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/centroid_update_ctrl.md
Name: centroid_update_ctrl

Overview:
Sequences the end-of-pass centroid update for the K-means engine. For each cluster it reads every engine's colour accumulators and pixel counter, sums them on one shared adder, and divides each colour sum by the count on one shared external divider. It then writes the new centroid to the centroid table. It replaces a fully parallel merge with a time-multiplexed one and sits between the per-engine accumulator banks, the shared divider and the centroid RAM.

Parameters:
K, 16, number of clusters
E, 2, number of accumulation engines
ACC_W, 24, per-engine, per-colour accumulator width
CNT_W, 12, per-engine pixel counter width
COL_W, 8, centroid colour width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse: begin update pass
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse at end of pass
empty_mask  out  K  bit k set if cluster k had total count 0 in the last pass
rd_en  out  1  accumulator read strobe
rd_eng  out  clog2(E)  engine select
rd_clu  out  clog2(K)  cluster select
rd_r, rd_g, rd_b  in  ACC_W each  read data, valid exactly 1 cycle after rd_en
rd_cnt  in  CNT_W  counter read data, valid 1 cycle after rd_en
div_req  out  1  divide request
div_ack  in  1  divider accepted request
div_num  out  ACC_W+clog2(E)  dividend
div_den  out  CNT_W+clog2(E)  divisor
div_done  in  1  one-cycle pulse: div_quot valid
div_quot  in  ACC_W+clog2(E)  quotient
cw_en  out  1  centroid write strobe
cw_addr  out  clog2(K)  centroid index
cw_r, cw_g, cw_b  out  COL_W each  centroid data

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, done, rd_en, div_req, cw_en = 0; empty_mask = 0; all address, data and sum registers = 0. Reset asserted mid-pass aborts the pass immediately and produces no done.
- States: IDLE, READ, DRAIN, DIV_R, DIV_G, DIV_B, WRITE, DONE.
- IDLE: start=1 clears the sums, sets k=0, clears empty_mask and goes to READ. start is ignored in every state except IDLE.
- READ: issues rd_en for e=0..E-1 on consecutive cycles with rd_clu=k. Read data for engine e is added to the r/g/b/cnt sums on the following cycle. Goes to DRAIN after the last issue.
- DRAIN: 1 cycle; adds the last engine's data. Next state is DIV_R, unless the total count is 0. In that case it sets empty_mask[k], skips division and write (the old centroid is kept), and goes to the next-cluster step.
- Read phase for one cluster takes exactly E+1 cycles.
- DIV_x: drives div_num = colour sum and div_den = count sum, and holds div_req=1 with stable operands until div_ack is sampled high. It then waits for div_done and latches the quotient.
  - If the quotient is greater than 2^COL_W-1 it saturates to 2^COL_W-1; otherwise its low COL_W bits are used.
  - div_done while no request is outstanding is ignored.
  - div_ack and div_done may arrive in the same cycle (0-latency divider); this counts as accepted and completed.
  - Sequence is DIV_R, then DIV_G, then DIV_B, then WRITE.
- WRITE: 1 cycle with cw_en=1, cw_addr=k and the latched r/g/b.
- Next-cluster step: if k=K-1, go to DONE; otherwise k=k+1, clear the sums and go to READ.
- DONE: done=1 for 1 cycle, busy goes to 0, return to IDLE. empty_mask holds until the next start.
- Sum widths: colour sums ACC_W+clog2(E); count sum CNT_W+clog2(E). Overflow is impossible by construction.
- rd_en, div_req and cw_en are never high in the same cycle.

Test Plan:
1. E=2, cluster 3: engine 0 has r/g/b = 1000/2000/3000 with cnt 10; engine 1 has 1000/0/600 with cnt 10; ideal divider. Required: cw_addr=3, cw_r/g/b = 100/100/180, cw_en exactly once for that cluster.
2. Cluster 5 with both counts 0 -> empty_mask[5]=1, no cw_en with cw_addr=5, divider not requested for it; the other 15 clusters are written; done after the last cluster.
3. Cluster 0 with r sum 600, count 2 -> quotient 300 saturates to cw_r=255.
4. Divider holds div_ack low for 5 cycles and returns div_done 7 cycles after ack -> div_req, div_num and div_den stable throughout; the result is correct.
5. start pulsed while busy -> ignored; exactly K writes and one done. rst_n pulled low during DIV_G of cluster 7 -> all outputs 0 immediately, no done; a new start afterwards completes normally.
6. Zero-latency divider (ack and done in the same cycle, all counts 1) -> the full pass completes. Total cycles from start to done are K*(E+1+3+1+1)+1 minus the empty-cluster savings; the bench checks the exact count.
